// File: rtl/vdp_pkg.sv
// Shared widths and types for the VDP VRAM arbiter slice.
package vdp_pkg;

    localparam int VRAM_AW   = 14;
    localparam int VRAM_DW   = 8;
    localparam int VGA_LANES = 8;

    typedef enum logic [1:0] {
        IDLE,
        RND_WAIT,
        CPU_WAIT
    } arb_state_t;

    typedef struct packed {
        logic               we;
        logic [VRAM_AW-1:0] addr;
        logic [VRAM_DW-1:0] wdata;
    } cpu_req_t;

endpackage

// File: rtl/vdp_vram_arbiter_if.sv
// Render requesters, CPU data port and both VRAM ports as seen by the arbiter.
interface vdp_vram_arbiter_if;
    import vdp_pkg::*;

    logic                           bg_req;
    logic [VGA_LANES*VRAM_AW-1:0]   bg_addr;
    logic [VGA_LANES-1:0]           bg_re;
    logic                           bg_gnt;
    logic                           spr_req;
    logic [VGA_LANES*VRAM_AW-1:0]   spr_addr;
    logic [VGA_LANES-1:0]           spr_re;
    logic                           spr_gnt;
    logic [VGA_LANES*VRAM_DW-1:0]   rnd_data;
    logic                           rnd_valid;
    logic                           rnd_id;
    logic                           cpu_req;
    logic                           cpu_we;
    logic [VRAM_AW-1:0]             cpu_addr;
    logic [VRAM_DW-1:0]             cpu_wdata;
    logic                           cpu_rdy;
    logic [VRAM_DW-1:0]             cpu_rdata;
    logic                           cpu_rvalid;
    logic [VGA_LANES*VRAM_AW-1:0]   vga_addr;
    logic [VGA_LANES-1:0]           vga_re;
    logic                           VRAM_go;
    logic [VRAM_AW-1:0]             io_addr;
    logic [VRAM_DW-1:0]             data_in;
    logic                           io_we;
    logic                           io_re;
    logic [VGA_LANES*VRAM_DW-1:0]   vga_data_out;
    logic [VRAM_DW-1:0]             io_data_out;

    // Requesters plus the VRAM itself.
    modport master (
        output bg_req, bg_addr, bg_re, spr_req, spr_addr, spr_re,
               cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_data_out, io_data_out,
        input  bg_gnt, spr_gnt, rnd_data, rnd_valid, rnd_id, cpu_rdy, cpu_rdata,
               cpu_rvalid, vga_addr, vga_re, VRAM_go, io_addr, data_in, io_we, io_re
    );

    // The arbiter.
    modport slave (
        input  bg_req, bg_addr, bg_re, spr_req, spr_addr, spr_re,
               cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_data_out, io_data_out,
        output bg_gnt, spr_gnt, rnd_data, rnd_valid, rnd_id, cpu_rdy, cpu_rdata,
               cpu_rvalid, vga_addr, vga_re, VRAM_go, io_addr, data_in, io_we, io_re
    );

endinterface

// File: rtl/vdp_req_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; DEPTH must be a power of 2 (>= 2).
module vdp_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage carries no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Arbitrates the VRAM render port between sprite/background fetch and queues CPU accesses
// onto the IO port between bursts, with a starvation guard for the CPU.
module vdp_vram_arbiter
    import vdp_pkg::*;
#(
    parameter int RD_LAT         = 2,
    parameter int CPU_FIFO_DEPTH = 2,
    parameter int STARVE_MAX     = 4
) (
    input  logic                clk,
    input  logic                rst_L,
    vdp_vram_arbiter_if.slave   bus
);

    localparam int LW = $clog2(RD_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(RD_LAT - 1);
    localparam logic [SW-1:0] STARVE_HI = SW'(STARVE_MAX);

    arb_state_t     state, state_nxt;
    logic [LW-1:0]  lat_cnt;
    logic [SW-1:0]  starve;
    logic           rd_last;
    logic           grant_spr, grant_bg, grant_cpu;
    cpu_req_t       fifo_din, fifo_head;
    logic           fifo_full, fifo_empty;

    assign fifo_din    = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
    assign bus.cpu_rdy = !fifo_full;
    assign rd_last     = (lat_cnt == LAT_LAST);

    vdp_req_fifo #(
        .DEPTH (CPU_FIFO_DEPTH),
        .WIDTH ($bits(cpu_req_t))
    ) u_cpu_fifo (
        .clk   (clk),
        .rst_L (rst_L),
        .push  (bus.cpu_req),
        .pop   (grant_cpu),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        grant_spr = 1'b0;
        grant_bg  = 1'b0;
        grant_cpu = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && starve == STARVE_HI) grant_cpu = 1'b1;
                else if (bus.spr_req)                   grant_spr = 1'b1;
                else if (bus.bg_req)                    grant_bg  = 1'b1;
                else if (!fifo_empty)                   grant_cpu = 1'b1;

                if (grant_spr || grant_bg)          state_nxt = RND_WAIT;
                else if (grant_cpu && !fifo_head.we) state_nxt = CPU_WAIT;
            end
            RND_WAIT: if (rd_last) state_nxt = IDLE;
            CPU_WAIT: if (rd_last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            lat_cnt        <= '0;
            starve         <= '0;
            bus.bg_gnt     <= 1'b0;
            bus.spr_gnt    <= 1'b0;
            bus.rnd_data   <= '0;
            bus.rnd_valid  <= 1'b0;
            bus.rnd_id     <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.vga_addr   <= '0;
            bus.vga_re     <= '0;
            bus.VRAM_go    <= 1'b0;
            bus.io_addr    <= '0;
            bus.data_in    <= '0;
            bus.io_we      <= 1'b0;
            bus.io_re      <= 1'b0;
        end else begin
            bus.bg_gnt     <= 1'b0;
            bus.spr_gnt    <= 1'b0;
            bus.VRAM_go    <= 1'b0;
            bus.io_we      <= 1'b0;
            bus.io_re      <= 1'b0;
            bus.rnd_valid  <= 1'b0;
            bus.cpu_rvalid <= 1'b0;

            if (state != IDLE) lat_cnt <= lat_cnt + LW'(1);

            if (grant_spr || grant_bg) begin
                bus.vga_addr <= grant_spr ? bus.spr_addr : bus.bg_addr;
                bus.vga_re   <= grant_spr ? bus.spr_re   : bus.bg_re;
                bus.VRAM_go  <= 1'b1;
                bus.spr_gnt  <= grant_spr;
                bus.bg_gnt   <= grant_bg;
                bus.rnd_id   <= grant_spr;
                lat_cnt      <= '0;
                // Only render grants taken while the CPU is waiting count toward starvation.
                if (fifo_empty)               starve <= '0;
                else if (starve != STARVE_HI) starve <= starve + SW'(1);
            end

            if (grant_cpu) begin
                bus.io_addr <= fifo_head.addr;
                bus.io_we   <= fifo_head.we;
                bus.io_re   <= !fifo_head.we;
                if (fifo_head.we) bus.data_in <= fifo_head.wdata;
                lat_cnt     <= '0;
                starve      <= '0;
            end

            if (state == RND_WAIT && rd_last) begin
                bus.rnd_data  <= bus.vga_data_out;
                bus.rnd_valid <= 1'b1;
            end

            if (state == CPU_WAIT && rd_last) begin
                bus.cpu_rdata  <= bus.io_data_out;
                bus.cpu_rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter with a behavioural dual-port VRAM (2-cycle read latency).
module tb_vdp_vram_arbiter;

    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    vdp_vram_arbiter_if bus ();

    vdp_vram_arbiter #(
        .RD_LAT         (RD_LAT),
        .CPU_FIFO_DEPTH (2),
        .STARVE_MAX     (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_L (rst_L),
        .bus   (bus)
    );

    // VRAM model: data registered one edge after the address is presented, captured by the
    // arbiter on the following edge.
    logic [7:0]  vram [16384];
    logic [63:0] vga_q;
    logic [7:0]  io_q;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            vga_q[8*i +: 8] <= bus.vga_re[i] ? vram[bus.vga_addr[14*i +: 14]] : 8'h00;
        io_q <= vram[bus.io_addr];
        if (bus.io_we) vram[bus.io_addr] <= bus.data_in;
    end

    assign bus.vga_data_out = vga_q;
    assign bus.io_data_out  = io_q;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int   spr_cnt;
    logic seen_io, seen_rv, resumed, seen_bad;
    logic [7:0] rv_data;
    logic [13:0] rv_addr;

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
        vram[14'h0100] = 8'hA5;
        vram[14'h0200] = 8'h11;
        vram[14'h0300] = 8'h22;
        vram[14'h0010] = 8'h77;
        bus.bg_req = 0; bus.bg_addr = '0; bus.bg_re = '0;
        bus.spr_req = 0; bus.spr_addr = '0; bus.spr_re = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

        // Reset state
        #12;
        check("rst_VRAM_go", bus.VRAM_go, 1'b0);
        check("rst_rnd_valid", bus.rnd_valid, 1'b0);
        check("rst_cpu_rdy", bus.cpu_rdy, 1'b1);
        check("rst_vga_addr", bus.vga_addr, 112'h0);
        check("rst_io_strobes", {bus.io_we, bus.io_re}, 2'b00);
        @(posedge clk); #2 rst_L = 1'b1;
        tick();

        // 1: single background burst, lane 0
        bus.bg_req = 1; bus.bg_addr[13:0] = 14'h0100; bus.bg_re = 8'h01;
        tick();
        check("t1_bg_gnt", bus.bg_gnt, 1'b1);
        check("t1_VRAM_go", bus.VRAM_go, 1'b1);
        check("t1_vga_addr", bus.vga_addr[13:0], 14'h0100);
        check("t1_vga_re", bus.vga_re, 8'h01);
        bus.bg_req = 0;
        tick();
        check("t1_go_drop", {bus.VRAM_go, bus.bg_gnt, bus.rnd_valid}, 3'b000);
        check("t1_vga_re_hold", bus.vga_re, 8'h01);
        tick();
        check("t1_rnd_valid", bus.rnd_valid, 1'b1);
        check("t1_rnd_id", bus.rnd_id, 1'b0);
        check("t1_rnd_data", bus.rnd_data, 64'h0000_0000_0000_00A5);

        // 2: sprite beats background, background stays pending
        bus.spr_req = 1; bus.spr_addr = '0; bus.spr_addr[3*14 +: 14] = 14'h0200; bus.spr_re = 8'h08;
        bus.bg_req = 1; bus.bg_addr = '0; bus.bg_addr[13:0] = 14'h0300; bus.bg_re = 8'h01;
        tick();
        check("t2_spr_gnt", {bus.spr_gnt, bus.bg_gnt}, 2'b10);
        bus.spr_req = 0;
        tick();
        tick();
        check("t2_spr_valid", {bus.rnd_valid, bus.rnd_id, bus.bg_gnt}, 3'b110);
        check("t2_spr_data", bus.rnd_data, 64'h0000_0000_1100_0000);
        tick();
        check("t2_bg_gnt", bus.bg_gnt, 1'b1);
        bus.bg_req = 0;
        tick();
        tick();
        check("t2_bg_valid", {bus.rnd_valid, bus.rnd_id}, 2'b10);
        check("t2_bg_data", bus.rnd_data, 64'h0000_0000_0000_0022);

        // 3: CPU write then read of the top address
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'h3FFF; bus.cpu_wdata = 8'h5A;
        tick();
        bus.cpu_we = 0;
        tick();
        bus.cpu_req = 0;
        check("t3_wr_strobe", {bus.io_we, bus.io_re}, 2'b10);
        check("t3_wr_addr", bus.io_addr, 14'h3FFF);
        check("t3_wr_data", bus.data_in, 8'h5A);
        tick();
        check("t3_rd_strobe", {bus.io_we, bus.io_re}, 2'b01);
        check("t3_rd_addr", bus.io_addr, 14'h3FFF);
        tick();
        check("t3_rvalid_early", bus.cpu_rvalid, 1'b0);
        tick();
        check("t3_rvalid", bus.cpu_rvalid, 1'b1);
        check("t3_rdata", bus.cpu_rdata, 8'h5A);
        tick();

        // 4: starvation guard against a continuous sprite request
        bus.spr_req = 1; bus.spr_addr = '0; bus.spr_addr[13:0] = 14'h0010; bus.spr_re = 8'h01;
        tick();
        check("t4_first_spr_gnt", bus.spr_gnt, 1'b1);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'h3FFF;
        tick();
        bus.cpu_req = 0;
        spr_cnt = 0; seen_io = 0; rv_addr = '0;
        for (int c = 0; c < 40 && !seen_io; c++) begin
            tick();
            if (bus.spr_gnt) spr_cnt++;
            if (bus.io_re) begin seen_io = 1; rv_addr = bus.io_addr; end
        end
        check("t4_io_re_seen", seen_io, 1'b1);
        check("t4_spr_gnt_count", spr_cnt, STARVE_MAX);
        check("t4_io_addr", rv_addr, 14'h3FFF);
        seen_rv = 0; resumed = 0; rv_data = '0;
        for (int c = 0; c < 10 && !resumed; c++) begin
            tick();
            if (bus.cpu_rvalid) begin seen_rv = 1; rv_data = bus.cpu_rdata; end
            if (bus.spr_gnt) resumed = 1;
        end
        check("t4_rvalid", seen_rv, 1'b1);
        check("t4_rdata", rv_data, 8'h5A);
        check("t4_spr_resume", resumed, 1'b1);
        bus.spr_req = 0;
        tick(); tick(); tick();

        // 5: three back-to-back pushes while a render burst is in flight
        bus.bg_req = 1; bus.bg_addr = '0; bus.bg_addr[13:0] = 14'h0100; bus.bg_re = 8'h01;
        tick();
        check("t5_bg_gnt", bus.bg_gnt, 1'b1);
        bus.bg_req = 0;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'h00A0; bus.cpu_wdata = 8'h01;
        #1 check("t5_rdy_empty", bus.cpu_rdy, 1'b1);
        tick();
        bus.cpu_addr = 14'h00A1; bus.cpu_wdata = 8'h02;
        tick();
        check("t5_rdy_full", bus.cpu_rdy, 1'b0);
        bus.cpu_addr = 14'h00A2; bus.cpu_wdata = 8'h03;
        tick();
        bus.cpu_req = 0;
        check("t5_io1", {bus.io_we, bus.io_addr, bus.data_in}, {1'b1, 14'h00A0, 8'h01});
        tick();
        check("t5_io2", {bus.io_we, bus.io_addr, bus.data_in}, {1'b1, 14'h00A1, 8'h02});
        tick();
        check("t5_no_io3", {bus.io_we, bus.io_re}, 2'b00);
        check("t5_rdy_back", bus.cpu_rdy, 1'b1);
        tick();
        check("t5_no_io3_late", {bus.io_we, bus.io_re}, 2'b00);

        // 6: reset while a render read is outstanding
        bus.bg_req = 1;
        tick();
        check("t6_bg_gnt", bus.bg_gnt, 1'b1);
        bus.bg_req = 0;
        #2 rst_L = 1'b0;
        #1;
        check("t6_async_clear", {bus.VRAM_go, bus.bg_gnt, bus.vga_re}, 10'h000);
        check("t6_async_addr", bus.vga_addr, 112'h0);
        @(posedge clk); #2 rst_L = 1'b1;
        seen_bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.rnd_valid) seen_bad = 1;
        end
        check("t6_no_stale_valid", seen_bad, 1'b0);
        bus.bg_req = 1;
        tick();
        check("t6_regrant", bus.bg_gnt, 1'b1);
        bus.bg_req = 0;
        tick();
        tick();
        check("t6_valid", bus.rnd_valid, 1'b1);
        check("t6_data", bus.rnd_data, 64'h0000_0000_0000_00A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vdp_vram_arbiter.md
Name: vdp_vram_arbiter

Overview:
- Sequences all access to the dual-port VRAM model.
- Shares the 8-lane render read port between two render requesters: background fetch and sprite fetch.
- Queues CPU data-port reads and writes and services them on the IO port between render bursts, with a starvation guard.
- Sits between the VDP render logic / IO decoder and the VRAM. Only this block drives VRAM_go.

Parameters:
- RD_LAT, 2: cycles from issue (VRAM_go / io_re high) to VRAM read data valid.
- CPU_FIFO_DEPTH, 2: CPU request queue entries. Must be a power of 2.
- STARVE_MAX, 4: consecutive render grants allowed while the CPU FIFO is non-empty.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_L  in  1  asynchronous, active-low reset.
- bg_req  in  1  background burst request; held until bg_gnt.
- bg_addr  in  112  eight 14-bit lane addresses, lane i at [14i+13:14i].
- bg_re  in  8  per-lane read enable.
- bg_gnt  out  1  one-cycle grant pulse.
- spr_req  in  1  sprite burst request; held until spr_gnt.
- spr_addr  in  112  eight 14-bit lane addresses.
- spr_re  in  8  per-lane read enable.
- spr_gnt  out  1  one-cycle grant pulse.
- rnd_data  out  64  render read data, lane i at [8i+7:8i].
- rnd_valid  out  1  one-cycle pulse when rnd_data is valid.
- rnd_id  out  1  0 = background, 1 = sprite; qualifies rnd_valid.
- cpu_req  in  1  CPU access valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  14  CPU access address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdy  out  1  FIFO not full; a request is accepted when cpu_req and cpu_rdy are both high.
- cpu_rdata  out  8  CPU read data.
- cpu_rvalid  out  1  one-cycle pulse when cpu_rdata is valid.
- vga_addr  out  112  to VRAM render port.
- vga_re  out  8  to VRAM render port.
- VRAM_go  out  1  render-port issue strobe.
- io_addr  out  14  to VRAM IO port.
- data_in  out  8  to VRAM IO port (write data).
- io_we  out  1  IO write strobe.
- io_re  out  1  IO read strobe.
- vga_data_out  in  64  from VRAM render port.
- io_data_out  in  8  from VRAM IO port.

Behaviour:
- Reset values: every output 0; FIFO empty; cpu_rdy=1 (combinational from FIFO full); state IDLE; starve counter 0.
- All VRAM-side outputs are registered. At most one operation is in flight.
- FSM states: IDLE, RND_WAIT, CPU_WAIT.
- IDLE, selection each cycle, in priority order:
  - (a) CPU FIFO non-empty and starve==STARVE_MAX;
  - (b) spr_req;
  - (c) bg_req;
  - (d) CPU FIFO non-empty.
- IDLE, render winner:
  - Register that requester's addr and re into vga_addr/vga_re, pulse VRAM_go, and pulse its gnt on the same edge.
  - Latch rnd_id. starve increments (saturating at STARVE_MAX) if the FIFO is non-empty, else it clears.
  - Go to RND_WAIT.
- IDLE, CPU winner:
  - Pop the FIFO head and drive io_addr; drive io_we+data_in for a write or io_re for a read. Strobe lasts one cycle. starve clears.
  - Write: return to IDLE on the next cycle.
  - Read: go to CPU_WAIT.
- Wait states:
  - RND_WAIT counts RD_LAT cycles. In the last cycle it captures vga_data_out into rnd_data, pulses rnd_valid, then goes to IDLE.
  - CPU_WAIT does the same with io_data_out into cpu_rdata and cpu_rvalid.
- Latency:
  - Render: req high in IDLE → gnt and VRAM_go next edge → rnd_valid RD_LAT cycles later.
  - Best-case render burst throughput is one per RD_LAT+1 cycles.
- vga_addr and vga_re hold their values after issue; VRAM_go and the io strobes return to 0.
- Simultaneous spr_req and bg_req: sprite wins. Background stays pending and is not dropped.
- FIFO:
  - Push and pop in the same cycle is legal and the count is unchanged.
  - Push while full is ignored (cpu_rdy=0).
  - Writes and reads complete in FIFO order.
  - A write followed by a read to the same address returns the new data.
- Render requests are never queued; the requester holds req.
- Reset mid-operation: all state clears immediately. In-flight data is dropped and no valid pulse is emitted. FIFO contents are lost.

Decomposition:
- Package vdp_pkg: VRAM_AW=14, VRAM_DW=8, VGA_LANES=8, arb_state_t enum (IDLE, RND_WAIT, CPU_WAIT), cpu_req_t struct {we, addr[13:0], wdata[7:0]}.
- One sub-module, vdp_req_fifo: parameterized depth and width, with push, pop, full, empty, and head outputs, instanced for the CPU queue.

Test Plan:
1. Reset then bg_req=1, bg_addr lane0=14'h0100, bg_re=8'h01, VRAM[0x100]=8'hA5 → bg_gnt and VRAM_go 1 cycle later; rnd_valid with rnd_id=0 and rnd_data[7:0]=8'hA5 exactly RD_LAT cycles after VRAM_go.
2. spr_req and bg_req asserted the same cycle → spr_gnt first, rnd_id=1; bg_gnt on the first IDLE after that result returns; bg is not lost.
3. CPU write 0x3FFF←8'h5A then read 0x3FFF, with no render traffic → io_we with io_addr=14'h3FFF, then cpu_rvalid with cpu_rdata=8'h5A.
4. spr_req held high continuously and one CPU read queued → exactly STARVE_MAX=4 spr_gnt pulses, then io_re, then sprite grants resume.
5. Three CPU pushes back-to-back while a render burst is in flight → cpu_rdy=0 after the 2nd push, the 3rd is ignored; two IO accesses issued in order.
6. rst_L low during RND_WAIT → outputs 0 asynchronously; no rnd_valid after release; next bg_req is serviced normally.
